// File: rtl/jk_ff_exerciser_if.sv
// Handshake bundle between the JK exerciser and the flip-flop under test.
// The exerciser owns the master side; the lab harness/bench owns the slave.
interface jk_ff_exerciser_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             dut_q;
  logic             j;
  logic             k;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_cnt;
  logic [7:0]       first_err;

  modport master (
    input  start, dut_q,
    output j, k, busy, done, pass, err_cnt, first_err
  );

  modport slave (
    output start, dut_q,
    input  j, k, busy, done, pass, err_cnt, first_err
  );
endinterface

// File: rtl/jk_ff_exerciser.sv
// Drives LFSR J/K vectors into a JK flip-flop and checks its Q
// against a reference model one cycle behind each applied vector.
module jk_ff_exerciser #(
  parameter int         N_VEC = 32,
  parameter logic [7:0] SEED  = 8'hA5,
  parameter int         ERR_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  jk_ff_exerciser_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [7:0] LSEED =
    (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] LAST = 8'(N_VEC - 1);

  state_t           r_state, w_state;
  logic [7:0]       r_lfsr, w_lfsr;
  logic [7:0]       r_idx, w_idx;
  logic             r_exp_q, w_exp_q;
  logic             r_j, w_j;
  logic             r_k, w_k;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic             r_pass, w_pass;
  logic [ERR_W-1:0] r_err, w_err;
  logic [7:0]       r_first, w_first;

  logic             w_chk;
  logic             w_mis;
  logic [7:0]       w_tag;
  logic [7:0]       w_lfsr_nx;
  logic             w_exp_nx;

  always_comb begin
    w_state = r_state;
    w_lfsr  = r_lfsr;
    w_idx   = r_idx;
    w_exp_q = r_exp_q;
    w_j     = r_j;
    w_k     = r_k;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_pass  = r_pass;
    w_err   = r_err;
    w_first = r_first;

    w_lfsr_nx = {r_lfsr[6:0],
                 r_lfsr[7] ^ r_lfsr[5] ^
                 r_lfsr[4] ^ r_lfsr[3]};

    unique case ({r_j, r_k})
      2'b00:   w_exp_nx = r_exp_q;
      2'b01:   w_exp_nx = 1'b0;
      2'b10:   w_exp_nx = 1'b1;
      default: w_exp_nx = ~r_exp_q;
    endcase

    // First RUN edge checks the INIT reset, tagged 8'hFE.
    w_chk = (r_state == S_RUN) ||
            (r_state == S_DRAIN);
    w_tag = (r_state == S_RUN && r_idx == 8'd0) ?
            8'hFE : r_idx - 8'd1;
    w_mis = w_chk && (bus.dut_q != r_exp_q);

    if (w_mis) begin
      if (r_err != '1)
        w_err = r_err + 1'b1;
      if (r_first == 8'hFF)
        w_first = w_tag;
    end

    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_err   = '0;
          w_first = 8'hFF;
          w_pass  = 1'b0;
          w_lfsr  = LSEED;
          w_j     = 1'b0;
          w_k     = 1'b1;
          w_busy  = 1'b1;
          w_state = S_INIT;
        end
      end
      S_INIT: begin
        w_exp_q = 1'b0;
        w_j     = r_lfsr[0];
        w_k     = r_lfsr[1];
        w_idx   = 8'd0;
        w_state = S_RUN;
      end
      S_RUN: begin
        w_exp_q = w_exp_nx;
        w_lfsr  = w_lfsr_nx;
        w_idx   = r_idx + 8'd1;
        if (r_idx == LAST) begin
          w_j     = 1'b0;
          w_k     = 1'b0;
          w_state = S_DRAIN;
        end else begin
          w_j = w_lfsr_nx[0];
          w_k = w_lfsr_nx[1];
        end
      end
      S_DRAIN: begin
        w_pass  = (w_err == '0);
        w_busy  = 1'b0;
        w_done  = 1'b1;
        w_state = S_DONE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lfsr  <= SEED;
      r_idx   <= 8'd0;
      r_exp_q <= 1'b0;
      r_j     <= 1'b0;
      r_k     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_first <= 8'hFF;
    end else begin
      r_state <= w_state;
      r_lfsr  <= w_lfsr;
      r_idx   <= w_idx;
      r_exp_q <= w_exp_q;
      r_j     <= w_j;
      r_k     <= w_k;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_pass  <= w_pass;
      r_err   <= w_err;
      r_first <= w_first;
    end
  end

  assign bus.j         = r_j;
  assign bus.k         = r_k;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_cnt   = r_err;
  assign bus.first_err = r_first;

endmodule

// File: tb/tb_jk_ff_exerciser.sv
// Bench for jk_ff_exerciser: three instances facing behavioural JK
// flops with selectable faults; results checked from a scoreboard.
module tb_jk_ff_exerciser;

  localparam int GOOD = 0;
  localparam int ST0  = 1;
  localparam int NTOG = 2;
  localparam int ST1  = 3;

  typedef struct {
    int     err;
    int     first;
    int     pass;
    longint cyc;
  } exp_t;

  bit     clk = 1'b0;
  bit     rst_n = 1'b0;
  longint cyc = 0;
  int     n_vec = 0;
  int     n_bad = 0;

  int     mode [3];
  bit     st   [3];
  bit     q    [3];
  logic   dq   [3];
  exp_t   sb   [3][$];

  logic       j_w [3];
  logic       k_w [3];
  logic       busy_w [3];
  logic       done_w [3];
  logic       pass_w [3];
  logic [7:0] err_w [3];
  logic [7:0] fe_w [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jk_ff_exerciser_if #(.ERR_W(8)) if0 ();
  jk_ff_exerciser_if #(.ERR_W(8)) if1 ();
  jk_ff_exerciser_if #(.ERR_W(2)) if2 ();

  jk_ff_exerciser #(
    .N_VEC(32), .SEED(8'hA5), .ERR_W(8)
  ) u0 (.clk(clk), .rst_n(rst_n), .bus(if0));

  jk_ff_exerciser #(
    .N_VEC(32), .SEED(8'h00), .ERR_W(8)
  ) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  jk_ff_exerciser #(
    .N_VEC(32), .SEED(8'hA5), .ERR_W(2)
  ) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  assign if0.start = st[0];
  assign if1.start = st[1];
  assign if2.start = st[2];
  assign if0.dut_q = dq[0];
  assign if1.dut_q = dq[1];
  assign if2.dut_q = dq[2];

  assign j_w[0] = if0.j;
  assign j_w[1] = if1.j;
  assign j_w[2] = if2.j;
  assign k_w[0] = if0.k;
  assign k_w[1] = if1.k;
  assign k_w[2] = if2.k;
  assign busy_w[0] = if0.busy;
  assign busy_w[1] = if1.busy;
  assign busy_w[2] = if2.busy;
  assign done_w[0] = if0.done;
  assign done_w[1] = if1.done;
  assign done_w[2] = if2.done;
  assign pass_w[0] = if0.pass;
  assign pass_w[1] = if1.pass;
  assign pass_w[2] = if2.pass;
  assign err_w[0] = if0.err_cnt;
  assign err_w[1] = if1.err_cnt;
  assign err_w[2] = {6'd0, if2.err_cnt};
  assign fe_w[0] = if0.first_err;
  assign fe_w[1] = if1.first_err;
  assign fe_w[2] = if2.first_err;

  function automatic bit jkf(
    input bit qi, input bit j, input bit k,
    input bit tog
  );
    case ({j, k})
      2'b00:   return qi;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return tog ? ~qi : qi;
    endcase
  endfunction

  // Flops under test; faults are applied on the Q output or toggle path.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    always @(posedge clk)
      q[g] <= jkf(q[g], j_w[g], k_w[g], mode[g] != NTOG);
    assign dq[g] = (mode[g] == ST0) ? 1'b0 :
                   (mode[g] == ST1) ? 1'b1 : q[g];
  end

  task automatic chk(
    input string nm, input longint act, input longint exp
  );
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Sequential reference of one run: INIT reset check, then N vectors.
  task automatic model(
    input logic [7:0] seed, input int n, input int md,
    input int emax, output int err, output int first
  );
    logic [7:0] l;
    bit e, d, j, k;
    l = (seed == 8'h00) ? 8'h01 : seed;
    e = 1'b0;
    d = (md == ST1);
    err = 0;
    first = 255;
    if (d != e) begin
      err = 1;
      first = 254;
    end
    for (int i = 0; i < n; i++) begin
      j = l[0];
      k = l[1];
      e = jkf(e, j, k, 1'b1);
      if (md == ST0) d = 1'b0;
      else if (md == ST1) d = 1'b1;
      else d = jkf(d, j, k, md != NTOG);
      if (d != e) begin
        if (err < emax) err++;
        if (first == 255) first = i;
      end
      l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (done_w[i]) begin
          if (sb[i].size() == 0) begin
            chk($sformatf("u%0d unexpected done", i), 1, 0);
          end else begin
            x = sb[i].pop_front();
            chk($sformatf("u%0d err_cnt", i), err_w[i], x.err);
            chk($sformatf("u%0d first_err", i), fe_w[i], x.first);
            chk($sformatf("u%0d pass", i), pass_w[i], x.pass);
            chk($sformatf("u%0d done cycle", i), cyc, x.cyc);
            chk($sformatf("u%0d busy at done", i), busy_w[i], 0);
          end
        end
      end
    end
  end

  task automatic run(
    input int i, input int md, input logic [7:0] seed,
    input int emax, input bit ej, input bit ek
  );
    exp_t x;
    int e, f;
    mode[i] = md;
    @(negedge clk);
    st[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    st[i] = 1'b0;
    model(seed, 32, md, emax, e, f);
    x.err = e;
    x.first = f;
    x.pass = (e == 0);
    x.cyc = cyc + 34;
    sb[i].push_back(x);
    chk($sformatf("u%0d busy after start", i), busy_w[i], 1);
    chk($sformatf("u%0d err cleared", i), err_w[i], 0);
    chk($sformatf("u%0d first_err cleared", i), fe_w[i], 255);
    @(negedge clk);
    chk($sformatf("u%0d first j", i), j_w[i], ej);
    chk($sformatf("u%0d first k", i), k_w[i], ek);
    for (int t = 0; t < 60 && sb[i].size() != 0; t++)
      @(negedge clk);
    if (sb[i].size() != 0) begin
      chk($sformatf("u%0d done timeout", i), 0, 1);
      sb[i].delete();
    end
  endtask

  task automatic chk_rst();
    chk("rst j", j_w[0], 0);
    chk("rst k", k_w[0], 0);
    chk("rst busy", busy_w[0], 0);
    chk("rst done", done_w[0], 0);
    chk("rst pass", pass_w[0], 0);
    chk("rst err_cnt", err_w[0], 0);
    chk("rst first_err", fe_w[0], 255);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      mode[i] = GOOD;
      st[i] = 1'b0;
    end
    #23;
    chk_rst();
    @(negedge clk);
    rst_n = 1'b1;

    run(0, GOOD, 8'hA5, 255, 1'b1, 1'b0);
    chk("good pass const", pass_w[0], 1);
    chk("good first const", fe_w[0], 255);
    run(0, ST0,  8'hA5, 255, 1'b1, 1'b0);
    chk("st0 pass const", pass_w[0], 0);
    run(0, NTOG, 8'hA5, 255, 1'b1, 1'b0);
    @(negedge clk);
    chk("ntog err held", err_w[0] != 0, 1);
    run(1, GOOD, 8'h00, 255, 1'b1, 1'b0);
    run(2, ST1,  8'hA5, 3,   1'b1, 1'b0);
    chk("st1 sat const", err_w[2], 3);
    chk("st1 first const", fe_w[2], 254);

    mode[0] = GOOD;
    @(negedge clk);
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_rst();
    @(negedge clk);
    rst_n = 1'b1;
    run(0, GOOD, 8'hA5, 255, 1'b1, 1'b0);
    chk("rerun pass const", pass_w[0], 1);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
